div_iter: RTL and testbench

Iterative 32-bit signed/unsigned divider for the EX stage. It produces the EX-stage multi-cycle stall request consumed by the pipeline hazard unit (`alu_stallE`). It also honours that unit's hold and flush decisions, so each DIV/DIVU retires exactly once with a stable HI/LO result. It is a radix-2 restoring divider with one quotient bit per cycle, plus a hold state that absorbs cache stalls after completion.

---
 rtl/div_iter.sv | 141 ++++++++++++++
 tb/tb_div_iter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage: one quotient bit per
// cycle, signed/unsigned, with a DONE hold state that absorbs downstream stalls.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_en,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hold,
  input  logic             flush,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } divState;

  divState state, stateNext;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] aRaw;
  logic             negQ;
  logic             negR;
  logic             divZero;

  logic             start;
  logic             lastStep;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;
  logic             qBit;
  logic [WIDTH-1:0] remStep;
  logic [WIDTH-1:0] dvdStep;
  logic [WIDTH-1:0] qFinal;
  logic [WIDTH-1:0] rFinal;

  assign start    = (state == IDLE) && div_en && !flush;
  assign lastStep = (state == RUN) && (cnt == LAST);

  assign div_stall = div_en && !flush && (state != DONE);

  assign absA = (div_signed && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
  assign absB = (div_signed && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

  // Remainder stays below the divisor, so WIDTH bits hold it between steps;
  // only the trial subtraction needs the extra bit for its sign.
  always_comb begin
    remShift = {rem, dvd[WIDTH-1]};
    trial    = remShift - {1'b0, dvs};
    qBit     = ~trial[WIDTH];
    remStep  = qBit ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
    dvdStep  = {dvd[WIDTH-2:0], qBit};
    if (divZero) begin
      qFinal = '1;
      rFinal = aRaw;
    end else begin
      qFinal = negQ ? (WIDTH'(0) - dvdStep) : dvdStep;
      rFinal = negR ? (WIDTH'(0) - remStep) : remStep;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (div_en) stateNext = RUN;
      RUN: begin
        if (!div_en)            stateNext = IDLE;
        else if (cnt == LAST)   stateNext = DONE;
      end
      DONE: if (!hold) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (flush) stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      aRaw         <= '0;
      negQ         <= 1'b0;
      negR         <= 1'b0;
      divZero      <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      result_valid <= 1'b0;
    end else if (flush) begin
      result_valid <= 1'b0;
    end else begin
      if (start) begin
        dvd     <= absA;
        dvs     <= absB;
        rem     <= '0;
        cnt     <= '0;
        aRaw    <= a;
        negQ    <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        negR    <= div_signed && a[WIDTH-1];
        divZero <= (b == '0);
      end
      if ((state == RUN) && div_en) begin
        dvd <= dvdStep;
        rem <= remStep;
        cnt <= cnt + 1'b1;
        if (lastStep) begin
          quotient     <= qFinal;
          remainder    <= rFinal;
          result_valid <= 1'b1;
        end
      end
      if ((state == DONE) && !hold) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signed/unsigned results,
// divide by zero, hold, flush, squash, back-to-back and asynchronous reset.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_en;
  logic        div_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        hold;
  logic        flush;
  logic        div_stall;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int failures = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk),
    .resetn(resetn),
    .div_en(div_en),
    .div_signed(div_signed),
    .a(a),
    .b(b),
    .hold(hold),
    .flush(flush),
    .div_stall(div_stall),
    .result_valid(result_valid),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic startOp(input logic [31:0] va, input logic [31:0] vb, input logic sgn);
    @(negedge clk);
    a = va; b = vb; div_signed = sgn; div_en = 1'b1; hold = 1'b0; flush = 1'b0;
    #1;
  endtask

  // Counts stall cycles from the current (start) cycle; returns in the first non-stall cycle.
  task automatic runToDone(output int stalls, output bit sawValid, input bit scramble);
    stalls = 0;
    sawValid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!div_stall) break;
      stalls++;
      if (result_valid) sawValid = 1'b1;
      if (scramble && i == 3) begin a = $urandom; b = $urandom; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (quotient !== 32'h0) begin failures++; $display("FAIL reset_q got=%h exp=%h", quotient, 32'h0); end
    checks++; if (remainder !== 32'h0) begin failures++; $display("FAIL reset_r got=%h exp=%h", remainder, 32'h0); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%b exp=0", div_stall); end
    div_en = 1'b1; #1;
    checks++; if (div_stall !== 1'b1) begin failures++; $display("FAIL reset_stall_follows_en got=%b exp=1", div_stall); end
    div_en = 1'b0;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_vectors(input string name, input logic sgn,
                              input logic [31:0] va[4], input logic [31:0] vb[4],
                              input logic [31:0] eq[4], input logic [31:0] er[4]);
    int stalls;
    bit sawValid;
    for (int i = 0; i < 4; i++) begin
      startOp(va[i], vb[i], sgn);
      runToDone(stalls, sawValid, 1'b0);
      checks++; if (stalls !== 33) begin failures++; $display("FAIL %s_latency[%0d] got=%0d exp=33", name, i, stalls); end
      checks++; if (sawValid !== 1'b0) begin failures++; $display("FAIL %s_early_valid[%0d] got=%b exp=0", name, i, sawValid); end
      checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL %s_valid[%0d] got=%b exp=1", name, i, result_valid); end
      checks++; if (quotient !== eq[i]) begin failures++; $display("FAIL %s_q[%0d] got=%h exp=%h", name, i, quotient, eq[i]); end
      checks++; if (remainder !== er[i]) begin failures++; $display("FAIL %s_r[%0d] got=%h exp=%h", name, i, remainder, er[i]); end
      div_en = 1'b0;
      @(negedge clk); #1;
      checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL %s_valid_drop[%0d] got=%b exp=0", name, i, result_valid); end
    end
  endtask

  task automatic test_divu;
    logic [31:0] va[4], vb[4], eq[4], er[4];
    va = '{32'd100, 32'hFFFFFFFF, 32'h80000000, 32'd3};
    vb = '{32'd7, 32'd1, 32'hFFFFFFFF, 32'd10};
    eq = '{32'd14, 32'hFFFFFFFF, 32'd0, 32'd0};
    er = '{32'd2, 32'd0, 32'h80000000, 32'd3};
    test_vectors("divu", 1'b0, va, vb, eq, er);
  endtask

  task automatic test_div_signed;
    logic [31:0] va[4], vb[4], eq[4], er[4];
    va = '{32'hFFFFFFF9, 32'h80000000, 32'd7, 32'hFFFFFF9C};
    vb = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF9};
    eq = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD, 32'd14};
    er = '{32'hFFFFFFFF, 32'd0, 32'd1, 32'hFFFFFFFE};
    test_vectors("div", 1'b1, va, vb, eq, er);
  endtask

  task automatic test_div_zero;
    logic [31:0] va[4], vb[4], eq[4], er[4];
    va = '{32'd5, 32'hFFFFFFFB, 32'd0, 32'h80000000};
    vb = '{32'd0, 32'd0, 32'd0, 32'd0};
    eq = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    er = '{32'd5, 32'hFFFFFFFB, 32'd0, 32'h80000000};
    test_vectors("divzero_u", 1'b0, va, vb, eq, er);
    test_vectors("divzero_s", 1'b1, va, vb, eq, er);
  endtask

  task automatic test_hold;
    int stalls;
    bit sawValid;
    startOp(32'd100, 32'd7, 1'b0);
    runToDone(stalls, sawValid, 1'b0);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL hold_latency got=%0d exp=33", stalls); end
    hold = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) begin hold = 1'b0; div_en = 1'b0; end
      checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b exp=1", k, result_valid); end
      checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL hold_stall[%0d] got=%b exp=0", k, div_stall); end
      checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL hold_q[%0d] got=%h exp=%h", k, quotient, 32'd14); end
      checks++; if (remainder !== 32'd2) begin failures++; $display("FAIL hold_r[%0d] got=%h exp=%h", k, remainder, 32'd2); end
      @(negedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid[%0d] got=%b exp=0", k, result_valid); end
      checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL hold_release_stall[%0d] got=%b exp=0", k, div_stall); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_flush;
    int stalls;
    bit sawValid;
    bit runValid;
    runValid = 1'b0;
    startOp(32'd1234, 32'd11, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk); #1;
      if (result_valid) runValid = 1'b1;
    end
    @(negedge clk); flush = 1'b1; #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", div_stall); end
    @(negedge clk); flush = 1'b0; div_en = 1'b0; #1;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", result_valid); end
    checks++; if (runValid !== 1'b0) begin failures++; $display("FAIL flush_run_valid got=%b exp=0", runValid); end
    startOp(32'hFFFFFC18, 32'd7, 1'b1);
    runToDone(stalls, sawValid, 1'b0);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL flush_next_latency got=%0d exp=33", stalls); end
    checks++; if (sawValid !== 1'b0) begin failures++; $display("FAIL flush_next_early_valid got=%b exp=0", sawValid); end
    checks++; if (quotient !== 32'hFFFFFF72) begin failures++; $display("FAIL flush_next_q got=%h exp=%h", quotient, 32'hFFFFFF72); end
    checks++; if (remainder !== 32'hFFFFFFFA) begin failures++; $display("FAIL flush_next_r got=%h exp=%h", remainder, 32'hFFFFFFFA); end
    div_en = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_flush_beats_start;
    int stalls;
    bit sawValid;
    @(negedge clk);
    a = 32'd20; b = 32'd3; div_signed = 1'b0; div_en = 1'b1; flush = 1'b1; #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL fbs_stall got=%b exp=0", div_stall); end
    @(negedge clk); flush = 1'b0; #1;
    runToDone(stalls, sawValid, 1'b0);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL fbs_latency got=%0d exp=33", stalls); end
    checks++; if (quotient !== 32'd6) begin failures++; $display("FAIL fbs_q got=%h exp=%h", quotient, 32'd6); end
    checks++; if (remainder !== 32'd2) begin failures++; $display("FAIL fbs_r got=%h exp=%h", remainder, 32'd2); end
    div_en = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_squash;
    int stalls;
    bit sawValid;
    startOp(32'd50, 32'd5, 1'b0);
    for (int k = 1; k <= 5; k++) begin @(negedge clk); #1; end
    div_en = 1'b0; #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL squash_stall got=%b exp=0", div_stall); end
    startOp(32'd77, 32'd4, 1'b0);
    runToDone(stalls, sawValid, 1'b0);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL squash_next_latency got=%0d exp=33", stalls); end
    checks++; if (quotient !== 32'd19) begin failures++; $display("FAIL squash_next_q got=%h exp=%h", quotient, 32'd19); end
    checks++; if (remainder !== 32'd1) begin failures++; $display("FAIL squash_next_r got=%h exp=%h", remainder, 32'd1); end
    div_en = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int stalls;
    bit sawValid;
    startOp(32'd1000, 32'd10, 1'b0);
    runToDone(stalls, sawValid, 1'b0);
    checks++; if (quotient !== 32'd100) begin failures++; $display("FAIL b2b_first_q got=%h exp=%h", quotient, 32'd100); end
    a = 32'hFFFFFFAF; b = 32'd9; div_signed = 1'b1;
    @(negedge clk); #1;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap_valid got=%b exp=0", result_valid); end
    runToDone(stalls, sawValid, 1'b1);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", stalls); end
    checks++; if (sawValid !== 1'b0) begin failures++; $display("FAIL b2b_early_valid got=%b exp=0", sawValid); end
    checks++; if (quotient !== 32'hFFFFFFF7) begin failures++; $display("FAIL b2b_q got=%h exp=%h", quotient, 32'hFFFFFFF7); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL b2b_r got=%h exp=%h", remainder, 32'd0); end
    div_en = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int stalls;
    bit sawValid;
    startOp(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 20; k++) begin @(negedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL rst_mid_q got=%h exp=%h", quotient, 32'd0); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL rst_mid_r got=%h exp=%h", remainder, 32'd0); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", result_valid); end
    checks++; if (div_stall !== 1'b1) begin failures++; $display("FAIL rst_mid_stall got=%b exp=1", div_stall); end
    @(negedge clk);
    resetn = 1'b1; a = 32'd1000; b = 32'd10; div_signed = 1'b0; #1;
    runToDone(stalls, sawValid, 1'b0);
    checks++; if (stalls !== 33) begin failures++; $display("FAIL rst_after_latency got=%0d exp=33", stalls); end
    checks++; if (quotient !== 32'd100) begin failures++; $display("FAIL rst_after_q got=%h exp=%h", quotient, 32'd100); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL rst_after_r got=%h exp=%h", remainder, 32'd0); end
    div_en = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0; div_en = 1'b0; div_signed = 1'b0;
    a = '0; b = '0; hold = 1'b0; flush = 1'b0;
    test_reset;
    test_divu;
    test_div_signed;
    test_div_zero;
    test_hold;
    test_flush;
    test_flush_beats_start;
    test_squash;
    test_back_to_back;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
